rot_shift_pipe: RTL and testbench
=================================

Name: rot_shift_pipe

Overview:
- Parametrised, pipelined rotate/shift unit. Successor to our fixed 8-bit, rotate-right-by-one combinational rotator.
- Supports any power-of-two width, variable shift amount, four modes (rotate right/left, logical/arithmetic shift right), and valid/ready handshakes on both sides.
- Sits between a producer and consumer datapath stage. The 2-stage register pipeline stalls cleanly under backpressure.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two, >= 2.
- SW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- din  input  WIDTH  data operand
- s  input  SW  shift/rotate amount, 0..WIDTH-1
- mode  input  2  00 ROR, 01 ROL, 10 LSR, 11 ASR
- din_valid  input  1  producer has a valid operand
- din_ready  output  1  block accepts the operand this cycle
- dout  output  WIDTH  result
- dout_valid  output  1  dout holds a valid result
- dout_ready  input  1  consumer accepts dout this cycle

Behaviour:
- Single clock domain; one clock and one reset, as already decided. Reset is asynchronous assert, active-low. No synchronous reset path.
- Reset values:
  - Stage-1 valid v1 = 0, stage-2 valid v2 = 0.
  - dout = 0, dout_valid = 0.
  - Stage-1 data/s/mode registers = 0.
- Pipeline control, combinational:
  - adv2 = !v2 | dout_ready
  - adv1 = !v1 | adv2
  - din_ready = adv1
- Transfers: input transfer when din_valid & din_ready; output transfer when dout_valid & dout_ready.
- Stage 1 (capture): when adv1, v1 <= din_valid and din/s/mode are registered. When !adv1, all stage-1 registers hold.
- Stage 2 (compute + register): when adv2, v2 <= v1 and dout <= f(stage-1 din, s, mode). When !adv2, dout and v2 hold.
- dout_valid = v2.
- Latency: exactly 2 clk edges from input transfer to dout_valid, absent stalls.
- Throughput: 1 result per cycle with dout_ready held high.
- f definitions (k = s):
  - ROR: dout[i] = din[(i+k) mod WIDTH]
  - ROL: dout[i] = din[(i-k) mod WIDTH]
  - LSR: din >> k, zero-filled
  - ASR: din >> k, filled with din[WIDTH-1]
- k = 0 returns din unchanged in every mode. s cannot exceed WIDTH-1 by construction; no saturation logic.
- Implementation: log2 barrel structure (SW mux layers), purely combinational between stage-1 and stage-2 registers. No latches. No assignment inside edge-sensitive always blocks except nonblocking register updates.
- Data integrity under backpressure:
  - dout is stable while dout_valid & !dout_ready.
  - No result is dropped or duplicated.
  - Order is preserved.
- Full pipeline with dout_ready = 0: v1 = v2 = 1, din_ready = 0, and din is ignored.
- Simultaneous events: with the pipe full and dout_ready = 1, an output transfer and an input transfer occur in the same cycle.
- din_valid may drop at any time. Bubbles propagate as v = 0. dout holds its last value when v2 = 0; the consumer must qualify with dout_valid.
- Reset mid-operation: all in-flight operands are discarded immediately on rst_n low. dout_valid drops asynchronously. After release, the first input is accepted on the first rising edge with din_valid = 1.
- X-safety: din/s/mode are don't-care while din_valid = 0. Outputs never go X after reset.

Test Plan:
- WIDTH=8, din=8'b10000001, mode=ROR, s=0..7, dout_ready=1.
  -> Results 2 cycles after each input: 10000001, 11000000, 01100000, 00110000, 00011000, 00001100, 00000110, 00000011.
- WIDTH=8, din=8'b11111110, ROR s=1 -> 01111111; ROR s=7 -> 11111101; ROL s=1 -> 11111101; ROL s=7 -> 01111111.
- WIDTH=8, din=8'h80: LSR s=3 -> 8'h10; ASR s=3 -> 8'hF0; ASR s=7 -> 8'hFF. din=8'h40, ASR s=3 -> 8'h08.
- Backpressure: stream 8'h01..8'h05 (ROL s=1) with dout_ready=0 for cycles 3-6.
  -> din_ready=0 once v1 and v2 are full.
  -> dout stable at 8'h02 during the stall.
  -> Outputs 02, 04, 06, 08, 0A in order, no loss or duplication.
- Reset mid-stream: assert rst_n=0 between clock edges with 2 operands in flight.
  -> dout_valid=0 and dout=0 immediately, with no clock edge.
  -> After release, new input 8'h81 ROR s=1 -> 8'hC0 in 2 cycles.
- WIDTH=32 instance: din=32'h8000_0001, ROR s=31 -> 32'h0000_0003; ASR s=4 on 32'h8000_0000 -> 32'hF800_0000.
  -> Checked against a reference model on 1000 random vectors with random dout_ready.

Source files
------------

// File: rtl/rot_shift_pipe_if.sv
// Valid/ready bus for the rotate/shift pipe.
// The master drives the operand and consumes the result; the slave is the pipe.
interface rot_shift_pipe_if #(
    parameter int WIDTH = 8
) ();
    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] din;
    logic [SW-1:0]    s;
    logic [1:0]       mode;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    modport master (
        output din, s, mode, din_valid, dout_ready,
        input  din_ready, dout, dout_valid
    );

    modport slave (
        input  din, s, mode, din_valid, dout_ready,
        output din_ready, dout, dout_valid
    );
endinterface

// File: rtl/rot_shift_pipe.sv
// Two-stage pipelined rotate/shift unit (ROR, ROL, LSR, ASR) with a log2 barrel
// between the capture and result registers; stalls cleanly under backpressure.
module rot_shift_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    rot_shift_pipe_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        MODE_ROR = 2'b00,
        MODE_ROL = 2'b01,
        MODE_LSR = 2'b10,
        MODE_ASR = 2'b11
    } mode_e;

    logic             v1;
    logic             v2;
    logic [WIDTH-1:0] d1;
    logic [SW-1:0]    s1;
    mode_e            m1;
    logic [WIDTH-1:0] q;
    logic             adv1;
    logic             adv2;
    logic [WIDTH-1:0] res;

    assign adv2 = !v2 || bus.dout_ready;
    assign adv1 = !v1 || adv2;

    assign bus.din_ready  = adv1;
    assign bus.dout_valid = v2;
    assign bus.dout       = q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            d1 <= '0;
            s1 <= '0;
            m1 <= MODE_ROR;
        end else if (adv1) begin
            v1 <= bus.din_valid;
            d1 <= bus.din;
            s1 <= bus.s;
            m1 <= mode_e'(bus.mode);
        end
    end

    // Layer j moves by 2**j when s1[j] is set; the ASR fill is the sign bit,
    // which every earlier layer has preserved in the MSB.
    for (genvar j = 0; j < SW; j++) begin : g_layer
        localparam int SH = 1 << j;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] o;

        if (j == 0) begin : g_first
            assign x = d1;
        end else begin : g_next
            assign x = g_layer[j-1].o;
        end

        always_comb begin
            y = x;
            unique case (m1)
                MODE_ROR: y = {x[SH-1:0], x[WIDTH-1:SH]};
                MODE_ROL: y = {x[WIDTH-SH-1:0], x[WIDTH-1:WIDTH-SH]};
                MODE_LSR: y = {{SH{1'b0}}, x[WIDTH-1:SH]};
                MODE_ASR: y = {{SH{x[WIDTH-1]}}, x[WIDTH-1:SH]};
            endcase
        end

        assign o = s1[j] ? y : x;
    end

    assign res = g_layer[SW-1].o;

    // The result register only loads real operands so that dout keeps its
    // last value across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            q  <= '0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                q <= res;
            end
        end
    end
endmodule

// File: tb/tb_rot_shift_pipe.sv
// Directed and randomised checks of rot_shift_pipe at WIDTH 8 and WIDTH 32.
module tb_rot_shift_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rot_shift_pipe_if #(.WIDTH(8))  bus8 ();
    rot_shift_pipe_if #(.WIDTH(32)) bus32 ();

    rot_shift_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
    rot_shift_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));

    always #5 clk = ~clk;

    localparam logic [1:0] ROR = 2'b00, ROL = 2'b01, LSR = 2'b10, ASR = 2'b11;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one8(input string tag, input logic [7:0] d, input logic [2:0] k,
                        input logic [1:0] m, input logic [7:0] e);
        bus8.din = d;
        bus8.s = k;
        bus8.mode = m;
        bus8.din_valid = 1'b1;
        step();
        bus8.din_valid = 1'b0;
        step();
        chk({tag, "_valid"}, 32'(bus8.dout_valid), 32'd1);
        chk(tag, 32'(bus8.dout), 32'(e));
    endtask

    task automatic one32(input string tag, input logic [31:0] d, input logic [4:0] k,
                         input logic [1:0] m, input logic [31:0] e);
        bus32.din = d;
        bus32.s = k;
        bus32.mode = m;
        bus32.din_valid = 1'b1;
        step();
        bus32.din_valid = 1'b0;
        step();
        chk({tag, "_valid"}, 32'(bus32.dout_valid), 32'd1);
        chk(tag, bus32.dout, e);
    endtask

    // Bit-by-bit reference written straight from the operation definitions.
    function automatic logic [31:0] ref32(input logic [31:0] d, input logic [4:0] k,
                                          input logic [1:0] m);
        logic [31:0] r;
        int kk;
        kk = int'(k);
        r = '0;
        for (int i = 0; i < 32; i++) begin
            case (m)
                ROR: r[i] = d[(i + kk) % 32];
                ROL: r[i] = d[(i - kk + 32) % 32];
                LSR: r[i] = (i + kk < 32) ? d[i + kk] : 1'b0;
                default: r[i] = (i + kk < 32) ? d[i + kk] : d[31];
            endcase
        end
        return r;
    endfunction

    initial begin
        logic [7:0] ror_exp [8];
        logic [7:0] bp_exp [5];
        logic [31:0] q [$];
        logic [31:0] held;
        logic stalled;
        int in_idx;
        int out_idx;
        int acc;
        int cyc;

        ror_exp = '{8'h81, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03};
        bp_exp  = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h0A};

        bus8.din = '0;  bus8.s = '0;  bus8.mode = ROR;  bus8.din_valid = 1'b0;  bus8.dout_ready = 1'b1;
        bus32.din = '0; bus32.s = '0; bus32.mode = ROR; bus32.din_valid = 1'b0; bus32.dout_ready = 1'b1;

        #3;
        chk("rst_valid8", 32'(bus8.dout_valid), 32'd0);
        chk("rst_dout8", 32'(bus8.dout), 32'd0);
        chk("rst_ready8", 32'(bus8.din_ready), 32'd1);
        chk("rst_valid32", 32'(bus32.dout_valid), 32'd0);
        chk("rst_dout32", bus32.dout, 32'd0);
        #9;
        rst_n = 1'b1;
        step();

        // Back-to-back ROR of 8'b10000001 by 0..7; each result appears two edges later.
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                bus8.din = 8'h81;
                bus8.s = 3'(i);
                bus8.mode = ROR;
                bus8.din_valid = 1'b1;
            end else begin
                bus8.din_valid = 1'b0;
            end
            step();
            if (i >= 1) begin
                chk("ror_stream_valid", 32'(bus8.dout_valid), 32'd1);
                chk("ror_stream", 32'(bus8.dout), 32'(ror_exp[i-1]));
            end
        end
        step();
        chk("bubble_valid", 32'(bus8.dout_valid), 32'd0);
        chk("bubble_hold", 32'(bus8.dout), 32'h03);

        one8("ror1_fe", 8'hFE, 3'd1, ROR, 8'h7F);
        one8("ror7_fe", 8'hFE, 3'd7, ROR, 8'hFD);
        one8("rol1_fe", 8'hFE, 3'd1, ROL, 8'hFD);
        one8("rol7_fe", 8'hFE, 3'd7, ROL, 8'h7F);
        one8("lsr3_80", 8'h80, 3'd3, LSR, 8'h10);
        one8("asr3_80", 8'h80, 3'd3, ASR, 8'hF0);
        one8("asr7_80", 8'h80, 3'd7, ASR, 8'hFF);
        one8("asr3_40", 8'h40, 3'd3, ASR, 8'h08);
        one8("rol0_a5", 8'hA5, 3'd0, ROL, 8'hA5);
        one8("lsr0_a5", 8'hA5, 3'd0, LSR, 8'hA5);
        one8("asr0_a5", 8'hA5, 3'd0, ASR, 8'hA5);
        step();
        chk("drain_valid", 32'(bus8.dout_valid), 32'd0);

        // Stream 01..05 through ROL 1 with the consumer stalled in cycles 3-6.
        bus8.mode = ROL;
        bus8.s = 3'd1;
        in_idx = 0;
        out_idx = 0;
        for (int c = 1; c <= 30 && out_idx < 5; c++) begin
            bus8.dout_ready = !(c >= 3 && c <= 6);
            bus8.din_valid = (in_idx < 5);
            bus8.din = 8'(in_idx + 1);
            #1;
            if (c >= 3 && c <= 6) begin
                chk("bp_din_ready", 32'(bus8.din_ready), 32'd0);
                chk("bp_hold_valid", 32'(bus8.dout_valid), 32'd1);
                chk("bp_hold", 32'(bus8.dout), 32'h02);
            end
            if (bus8.dout_valid && bus8.dout_ready) begin
                chk("bp_out", 32'(bus8.dout), 32'(bp_exp[out_idx]));
                out_idx++;
            end
            if (bus8.din_valid && bus8.din_ready) in_idx++;
            @(posedge clk);
            #1;
        end
        chk("bp_out_count", 32'(out_idx), 32'd5);
        chk("bp_in_count", 32'(in_idx), 32'd5);

        // Reset between edges with two operands in flight.
        bus8.dout_ready = 1'b1;
        bus8.mode = ROR;
        bus8.s = 3'd1;
        bus8.din = 8'h11;
        bus8.din_valid = 1'b1;
        step();
        bus8.din = 8'h22;
        step();
        chk("pre_rst_valid", 32'(bus8.dout_valid), 32'd1);
        bus8.din_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus8.dout_valid), 32'd0);
        chk("mid_rst_dout", 32'(bus8.dout), 32'd0);
        chk("mid_rst_ready", 32'(bus8.din_ready), 32'd1);
        #1;
        rst_n = 1'b1;
        bus8.din = 8'h81;
        bus8.s = 3'd1;
        bus8.mode = ROR;
        bus8.din_valid = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus8.din_ready), 32'd1);
        step();
        bus8.din_valid = 1'b0;
        chk("post_rst_flushed", 32'(bus8.dout_valid), 32'd0);
        step();
        chk("post_rst_valid", 32'(bus8.dout_valid), 32'd1);
        chk("post_rst_dout", 32'(bus8.dout), 32'hC0);

        one32("ror31_w32", 32'h8000_0001, 5'd31, ROR, 32'h0000_0003);
        one32("asr4_w32", 32'h8000_0000, 5'd4, ASR, 32'hF800_0000);
        one32("rol0_w32", 32'h1234_5678, 5'd0, ROL, 32'h1234_5678);
        step();

        // Random operands and random backpressure against the reference model.
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 5000) begin
            bus32.dout_ready = ($urandom_range(0, 3) != 0);
            bus32.din_valid = ($urandom_range(0, 3) != 0);
            bus32.din = $urandom;
            bus32.s = 5'($urandom);
            bus32.mode = 2'($urandom);
            #1;
            if (bus32.dout_valid && bus32.dout_ready) begin
                if (q.size() == 0) chk("rnd_extra_out", 32'(q.size()), 32'd1);
                else chk("rnd_out", bus32.dout, q.pop_front());
            end
            stalled = bus32.dout_valid && !bus32.dout_ready;
            held = bus32.dout;
            if (bus32.din_valid && bus32.din_ready) begin
                q.push_back(ref32(bus32.din, bus32.s, bus32.mode));
                acc++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (stalled) begin
                chk("rnd_hold_valid", 32'(bus32.dout_valid), 32'd1);
                chk("rnd_hold", bus32.dout, held);
            end
        end
        chk("rnd_accepted", 32'(acc), 32'd1000);
        bus32.din_valid = 1'b0;
        bus32.dout_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            #1;
            if (bus32.dout_valid) chk("rnd_drain_out", bus32.dout, q.pop_front());
            @(posedge clk);
            #1;
        end
        chk("rnd_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
